fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the asynchronous FIFO among `N_REQ` requesters in the write-clock domain. It holds each granted word in a one-entry register and drives the FIFO write increment only when the FIFO reports not-full. It sits between the system's write-domain producers (register file, ALU result path, UART TX loader) and the FIFO write side.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 80 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding and pointer-width function.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request at or above rr_ptr.
// Double-width rotation, then lowest set bit of the rotated vector.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;

    assign any = |req;

    always_comb begin
        rot = N'({req, req} >> rr_ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = PW'(k);
        end
        // offset is relative to rr_ptr; fold back into 0..N-1
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        winner = sum[PW-1:0];
        grant = '0;
        if (any) grant[winner] = 1'b1;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port.
// One-entry hold register drains whenever the FIFO is not full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        wclk,
    input  logic                        wrst_n,
    input  logic                        arb_en,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    input  logic                        fifo_full,
    output logic                        fifo_w_inc,
    output logic [DATA_WIDTH-1:0]       fifo_wdata,
    output logic                        busy
);

    localparam int PW = clog2(N_REQ);

    arb_state_t            state_q, state_d;
    logic [PW-1:0]         rr_ptr_q;
    logic [PW-1:0]         winner;
    logic [N_REQ-1:0]      grant;
    logic                  any;
    logic                  can_grant;
    logic                  fire;
    logic [DATA_WIDTH-1:0] wdata_q;

    rr_priority_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        can_grant = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            ST_IDLE:  can_grant = arb_en;
            ST_ISSUE: can_grant = arb_en && !fifo_full;
            default:  can_grant = 1'b0;
        endcase
        fire = can_grant && any;
        // a full FIFO pins the held word in place
        if (fire)
            state_d = ST_ISSUE;
        else if (state_q == ST_ISSUE && fifo_full)
            state_d = ST_ISSUE;
        else
            state_d = ST_IDLE;
    end

    assign ack        = (fire && wrst_n) ? grant : '0;
    assign fifo_w_inc = wrst_n && (state_q == ST_ISSUE) && !fifo_full;
    assign fifo_wdata = wdata_q;
    assign busy       = (state_q == ST_ISSUE);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                wdata_q  <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr_q <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// Directed plan scenarios plus randomized traffic against a queue-free model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            wclk;
    logic            wrst_n;
    logic            arb_en;
    logic [N-1:0]    req;
    logic [DW-1:0]   d [N];
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            fifo_full;
    logic            fifo_w_inc;
    logic [DW-1:0]   fifo_wdata;
    logic            busy;

    assign req_data = {d[3], d[2], d[1], d[0]};

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .arb_en     (arb_en),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_w_inc (fifo_w_inc),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // behavioural model: is a word held, what word, where the search starts
    bit        m_held = 0;
    bit [7:0]  m_data = 0;
    int        m_ptr  = 0;

    int        e_win;
    bit        e_fire;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic void predict();
        bit can;
        can = arb_en && (!m_held || !fifo_full);
        e_win = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (e_win < 0 && req[idx]) e_win = idx;
        end
        e_fire = wrst_n && can && (e_win >= 0);
    endfunction

    task automatic sample();
        logic [N-1:0] e_ack;
        @(negedge wclk);
        predict();
        e_ack = e_fire ? N'(1 << e_win) : '0;
        chk("ack", 32'(ack), 32'(e_ack));
        chk("w_inc", 32'(fifo_w_inc),
            32'(wrst_n && m_held && !fifo_full));
        chk("wdata", 32'(fifo_wdata), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_held));
    endtask

    task automatic advance();
        @(posedge wclk);
        predict();
        if (!wrst_n) begin
            m_held = 0;
            m_data = 0;
            m_ptr  = 0;
        end else if (e_fire) begin
            m_data = d[e_win];
            m_ptr  = (e_win + 1) % N;
            m_held = 1;
        end else if (!(m_held && fifo_full)) begin
            m_held = 0;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        logic [N-1:0] last_ack;
        wrst_n    = 1'b0;
        arb_en    = 1'b1;
        fifo_full = 1'b0;
        req       = 4'b1111;
        for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);

        // reset with every requester active
        advance();
        sample();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_winc", 32'(fifo_w_inc), 0);
        chk("rst_wdata", 32'(fifo_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        advance();

        // round robin over all four
        wrst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("rr_ack", 32'(ack), 32'(1 << (i % 4)));
            if (i > 0) begin
                chk("rr_winc", 32'(fifo_w_inc), 1);
                chk("rr_wdata", 32'(fifo_wdata), 32'(8'hA0 + 8'((i - 1) % 4)));
            end
            advance();
        end
        req = '0;
        cyc();

        // full stall on requester 2
        req  = 4'b0100;
        d[2] = 8'h5C;
        sample();
        chk("st_ack", 32'(ack), 32'(4'b0100));
        advance();
        req       = '0;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("st_wdata", 32'(fifo_wdata), 32'h5C);
            chk("st_winc", 32'(fifo_w_inc), 0);
            chk("st_ack0", 32'(ack), 0);
            advance();
        end
        fifo_full = 1'b0;
        req       = 4'b0001;
        sample();
        chk("st_rel_winc", 32'(fifo_w_inc), 1);
        chk("st_rel_ack", 32'(ack), 32'(4'b0001));
        advance();
        req = '0;
        cyc();
        cyc();

        // enable gating
        arb_en = 1'b0;
        req    = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("en_ack0", 32'(ack), 0);
            advance();
        end
        arb_en = 1'b1;
        sample();
        chk("en_ack", 32'(ack), 32'(4'b0010));
        advance();
        arb_en = 1'b0;
        req    = 4'b0100;
        sample();
        chk("en_drain", 32'(fifo_w_inc), 1);
        chk("en_drain_ack", 32'(ack), 0);
        advance();
        sample();
        chk("en_idle", 32'(busy), 0);
        chk("en_idle_winc", 32'(fifo_w_inc), 0);
        advance();

        // sparse requests with wrap; first park the pointer at 1
        arb_en = 1'b1;
        req    = 4'b0001;
        sample();
        chk("wr_park", 32'(ack), 32'(4'b0001));
        advance();
        req = 4'b1001;
        sample();
        chk("wr_hi", 32'(ack), 32'(4'b1000));
        advance();
        sample();
        chk("wr_lo", 32'(ack), 32'(4'b0001));
        advance();
        req = '0;
        cyc();
        cyc();

        // reset while a word waits behind a full FIFO
        req = 4'b0100;
        cyc();
        req       = '0;
        fifo_full = 1'b1;
        cyc();
        wrst_n = 1'b0;
        cyc();
        wrst_n    = 1'b1;
        fifo_full = 1'b0;
        sample();
        chk("mr_busy", 32'(busy), 0);
        chk("mr_winc", 32'(fifo_w_inc), 0);
        advance();
        cyc();

        // randomized traffic; requesters hold until acked, occasionally give up
        last_ack = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] nreq;
            nreq = req & ~last_ack;
            for (int i = 0; i < N; i++) begin
                if (!nreq[i] && $urandom_range(0, 99) < 40) begin
                    nreq[i] = 1'b1;
                    d[i]    = 8'($urandom);
                end else if (nreq[i] && $urandom_range(0, 99) < 3) begin
                    nreq[i] = 1'b0;
                end
            end
            req       = nreq;
            fifo_full = ($urandom_range(0, 99) < 30);
            arb_en    = ($urandom_range(0, 99) < 85);
            wrst_n    = ($urandom_range(0, 199) != 0);
            sample();
            last_ack = ack;
            advance();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
